// File: rtl/seg7_scan_driver_if.sv
// Display-register side of the 7-segment scan driver.
// The register is level-sampled: there is no valid/ready handshake. The
// driver copies data, blank_lz and dp_mask once per frame, on the last
// cycle of the last digit slot. The master may change the values at any
// time; a change becomes visible at the next frame boundary.
interface seg7_scan_driver_if;
   logic [31:0] data;
   logic        blank_lz;
   logic [7:0]  dp_mask;

   modport master (output data, output blank_lz, output dp_mask);
   modport slave  (input  data, input  blank_lz, input  dp_mask);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Shows a 32-bit value as 8 hex digits (nibble 0 = rightmost), one digit per
// slot, with a per-frame snapshot, a blanked guard interval at the start of
// each slot, optional leading-zero blanking and per-digit decimal points.
// All pin outputs are registered and active-low.
module seg7_scan_driver #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 2000
) (
   input  logic                     clk,
   input  logic                     rst,
   seg7_scan_driver_if.slave        bus,
   output logic [7:0]               led_en,
   output logic                     led_ca,
   output logic                     led_cb,
   output logic                     led_cc,
   output logic                     led_cd,
   output logic                     led_ce,
   output logic                     led_cf,
   output logic                     led_cg,
   output logic                     led_dp
);

   localparam int            CW   = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [31:0]   shadow;
   logic [7:0]    dp_shadow;
   logic          blz_shadow;
   logic          slot_end;
   logic          in_guard;

   logic [31:0]   upper;
   logic [3:0]    nib;
   logic          blank;
   logic [7:0]    en_d;
   logic [6:0]    seg_d;
   logic          dp_d;
   logic [6:0]    seg_n;

   // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign slot_end = (cnt == LAST);

   // With no guard interval every cycle drives a digit; a separate branch
   // avoids an always-false unsigned compare against zero.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CW'(GUARD));
      end
   endgenerate

   // Slot counter and digit index; idx advances on the last cycle of a slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 3'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Frame snapshot: capture the register at the very end of digit 7 so a
   // whole frame is drawn from one consistent value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= '0;
         dp_shadow  <= '0;
         blz_shadow <= 1'b0;
      end else if (slot_end && (idx == 3'd7)) begin
         shadow     <= bus.data;
         dp_shadow  <= bus.dp_mask;
         blz_shadow <= bus.blank_lz;
      end
   end

   // Select the current nibble and decide blanking; a digit is a leading
   // zero when it and every nibble above it are zero (digit 0 is exempt).
   always_comb begin
      upper = shadow >> {idx, 2'b00};
      nib   = upper[3:0];
      blank = (idx != 3'd0) && blz_shadow && (upper == 32'd0);
      en_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!in_guard) begin
         en_d = ~(8'b1 << idx);
         dp_d = ~dp_shadow[idx];
         if (!blank) begin
            seg_d = ~hex7(nib);
         end
      end
   end

   // Registered, active-low pin drivers; reset darkens everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_en <= 8'hFF;
         seg_n  <= 7'h7F;
         led_dp <= 1'b1;
      end else begin
         led_en <= en_d;
         seg_n  <= seg_d;
         led_dp <= dp_d;
      end
   end

   assign led_ca = seg_n[0];
   assign led_cb = seg_n[1];
   assign led_cc = seg_n[2];
   assign led_cd = seg_n[3];
   assign led_ce = seg_n[4];
   assign led_cf = seg_n[5];
   assign led_cg = seg_n[6];

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4. dut_g1 uses GUARD=1,
// dut_g0 uses GUARD=0; both share clock, reset and the display register.
// Pins are compared as {led_en[7:0], {g..a} active-low, led_dp}.
module tb_seg7_scan_driver;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   n;

   seg7_scan_driver_if bus ();

   logic [7:0] en1, en0;
   logic ca1, cb1, cc1, cd1, ce1, cf1, cg1, dp1;
   logic ca0, cb0, cc0, cd0, ce0, cf0, cg0, dp0;
   logic [15:0] pins1, pins0;

   assign pins1 = {en1, cg1, cf1, ce1, cd1, cc1, cb1, ca1, dp1};
   assign pins0 = {en0, cg0, cf0, ce0, cd0, cc0, cb0, ca0, dp0};

   seg7_scan_driver #(.SCAN_DIV(4), .GUARD(1)) dut_g1 (
      .clk(clk), .rst(rst), .bus(bus),
      .led_en(en1), .led_ca(ca1), .led_cb(cb1), .led_cc(cc1), .led_cd(cd1),
      .led_ce(ce1), .led_cf(cf1), .led_cg(cg1), .led_dp(dp1)
   );

   seg7_scan_driver #(.SCAN_DIV(4), .GUARD(0)) dut_g0 (
      .clk(clk), .rst(rst), .bus(bus),
      .led_en(en0), .led_ca(ca0), .led_cb(cb0), .led_cc(cc0), .led_cd(cd0),
      .led_ce(ce0), .led_cf(cf0), .led_cg(cg0), .led_dp(dp0)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled on the falling edge. Every cycle the
   // GUARD=1 part must have at most one digit on, the GUARD=0 part exactly one.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      n++;
      checks++;
      assert ($countones(~en1) <= 1) else begin
         errors++;
         $error("FAIL onehot_g1 observed=%h expected=at_most_one_low", en1);
      end
      checks++;
      assert ($countones(~en0) == 1) else begin
         errors++;
         $error("FAIL onehot_g0 observed=%h expected=exactly_one_low", en0);
      end
   endtask

   // Advance until the outputs reflect slot position (frame f, digit i, cnt c).
   task automatic goto(input int f, input int i, input int c);
      int tgt;
      tgt = f * 32 + i * 4 + c + 1;
      while (n < tgt) tick();
      if (n != tgt) begin
         errors++;
         $error("FAIL sequence observed=%0d expected=%0d", n, tgt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      n = 0;
      rst = 1'b1;
      bus.data = 32'h12345678;
      bus.blank_lz = 1'b0;
      bus.dp_mask = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_g1", pins1, 16'hFFFF);
      check("reset_g0", pins0, 16'hFFFF);
      rst = 1'b0;
      n = 0;

      // Frame 0 draws the cleared shadow: "0" everywhere.
      tick();
      check("f0_guard", pins1, 16'hFFFF);
      check("f0_g0_d0", pins0, {8'hFE, 7'h40, 1'b1});
      goto(0, 0, 1);
      check("f0_d0", pins1, {8'hFE, 7'h40, 1'b1});
      goto(0, 7, 3);
      check("f0_d7", pins1, {8'h7F, 7'h40, 1'b1});

      // Frame 1 shows 12345678.
      goto(1, 0, 0);
      check("f1_guard", pins1, 16'hFFFF);
      check("f1_g0_d0", pins0, {8'hFE, 7'h00, 1'b1});
      goto(1, 0, 1);
      check("f1_d0_8", pins1, {8'hFE, 7'h00, 1'b1});
      goto(1, 3, 1);
      check("f1_d3_5", pins1, {8'hF7, 7'h12, 1'b1});
      goto(1, 7, 2);
      check("f1_d7_1", pins1, {8'h7F, 7'h79, 1'b1});

      // Tearing: frame 2 shows A; a mid-frame write waits for frame 3.
      bus.data = 32'hAAAAAAAA;
      goto(2, 3, 1);
      check("f2_d3_A", pins1, {8'hF7, 7'h08, 1'b1});
      bus.data = 32'h55555555;
      goto(2, 4, 1);
      check("f2_d4_A", pins1, {8'hEF, 7'h08, 1'b1});
      goto(2, 7, 3);
      check("f2_d7_A", pins1, {8'h7F, 7'h08, 1'b1});
      goto(3, 0, 1);
      check("f3_d0_5", pins1, {8'hFE, 7'h12, 1'b1});
      goto(3, 6, 0);
      check("f3_d6_guard", pins1, 16'hFFFF);
      goto(3, 6, 2);
      check("f3_d6_5", pins1, {8'hBF, 7'h12, 1'b1});

      // Leading-zero blanking with decimal points on digits 0 and 2.
      bus.data = 32'h000000F0;
      bus.blank_lz = 1'b1;
      bus.dp_mask = 8'b0000_0101;
      goto(4, 0, 1);
      check("f4_d0_0dp", pins1, {8'hFE, 7'h40, 1'b0});
      goto(4, 1, 1);
      check("f4_d1_F", pins1, {8'hFD, 7'h0E, 1'b1});
      goto(4, 2, 0);
      check("f4_d2_guard", pins1, 16'hFFFF);
      goto(4, 2, 1);
      check("f4_d2_blankdp", pins1, {8'hFB, 7'h7F, 1'b0});
      goto(4, 5, 3);
      check("f4_d5_blank", pins1, {8'hDF, 7'h7F, 1'b1});
      goto(4, 7, 1);
      check("f4_d7_blank", pins1, {8'h7F, 7'h7F, 1'b1});

      // data=0 with blanking: only digit 0 draws "0".
      bus.data = 32'h00000000;
      goto(5, 0, 2);
      check("f5_d0_0dp", pins1, {8'hFE, 7'h40, 1'b0});
      goto(5, 1, 1);
      check("f5_d1_blank", pins1, {8'hFD, 7'h7F, 1'b1});
      goto(5, 2, 3);
      check("f5_d2_blankdp", pins1, {8'hFB, 7'h7F, 1'b0});
      goto(5, 7, 1);
      check("f5_d7_blank", pins1, {8'h7F, 7'h7F, 1'b1});

      // Interior zeros stay visible; only zeros above the top digit blank.
      bus.data = 32'h00100200;
      bus.dp_mask = 8'h00;
      goto(6, 3, 1);
      check("f6_d3_0", pins1, {8'hF7, 7'h40, 1'b1});
      goto(6, 5, 1);
      check("f6_d5_1", pins1, {8'hDF, 7'h79, 1'b1});
      goto(6, 6, 1);
      check("f6_d6_blank", pins1, {8'hBF, 7'h7F, 1'b1});

      // Reset mid-slot with cnt=2, idx=5.
      goto(7, 5, 1);
      check("f7_d5_1", pins1, {8'hDF, 7'h79, 1'b1});
      rst = 1'b1;
      #1;
      check("midrst_g1", pins1, 16'hFFFF);
      check("midrst_g0", pins0, 16'hFFFF);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      tick();
      check("rst_guard", pins1, 16'hFFFF);
      check("rst_g0_d0", pins0, {8'hFE, 7'h40, 1'b1});
      goto(0, 0, 1);
      check("rst_d0_0", pins1, {8'hFE, 7'h40, 1'b1});
      goto(0, 5, 1);
      check("rst_d5_0", pins1, {8'hDF, 7'h40, 1'b1});
      check("rst_g0_d5", pins0, {8'hDF, 7'h40, 1'b1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 8-digit, common-anode 7-segment display.
- Consumes the 32-bit value held by the memory-mapped display register and shows it as 8 hex digits. Nibble 0 is the rightmost digit.
- Scans one digit per slot. Adds a per-frame snapshot (no tearing), a guard/blanking interval (no ghosting), optional leading-zero blanking and per-digit decimal points.
- All pin outputs are registered, active-low.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (100 MHz -> 2 kHz digit rate, 250 Hz frame); legal range >= 2.
- GUARD, 2000, cycles at the start of each slot with all digits disabled; legal range 0 <= GUARD < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- data  in  32  value to display, nibble i -> digit i
- blank_lz  in  1  1 = suppress leading zero digits (digit 0 never suppressed)
- dp_mask  in  8  bit i = 1 lights the decimal point of digit i
- led_en  out  8  digit enables, active-low, bit i = digit i
- led_ca..led_cg  out  1 each  segments a..g, active-low
- led_dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, rst=1):
  - cnt=0, idx=0, shadow=0.
  - led_en=8'hFF; all segments and led_dp = 1 (everything dark).
- Slot counter cnt:
  - Counts 0..SCAN_DIV-1 every clk, then wraps to 0.
  - On the wrap cycle (cnt==SCAN_DIV-1), idx increments, 7 -> 0.
- Frame snapshot:
  - When cnt==SCAN_DIV-1 and idx==7, shadow <= data (and dp_mask, blank_lz into shadow copies).
  - Display content changes only at frame boundaries. Writes to data mid-frame are not visible until the next frame.
  - The first frame after reset shows shadow=0.
- Output registers, updated every cycle from the current (cnt, idx, shadow); one cycle latency:
  - If cnt < GUARD: led_en <= 8'hFF, segments <= all 1, led_dp <= 1.
  - Otherwise: led_en <= ~(8'b1 << idx), segments <= ~hex7(nib), led_dp <= ~dp_shadow[idx], where nib = shadow[4*idx+3:4*idx].
  - If the digit is blanked: led_en keeps the selected digit low, segments all 1, led_dp still follows dp_shadow[idx].
- hex7 {g,f,e,d,c,b,a} active-high patterns:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Leading-zero blanking:
  - Digit i (i>=1) is blank iff blank_lz_shadow=1 and shadow[31:4*i]==0.
  - shadow==0 with blanking on shows a single "0" on digit 0.
- Invariants:
  - At most one led_en bit is low in any cycle.
  - Zero led_en bits are low during guard cycles.
- GUARD=0: no guard interval; a digit is enabled every cycle.
- Reset mid-slot: all outputs go dark immediately (asynchronous). Scan restarts at idx 0, cnt 0, and the shadow is cleared.
- Counter width $clog2(SCAN_DIV); no other arithmetic.

Test Plan (SCAN_DIV=4, GUARD=1 unless noted):
- Reset release, data=32'h12345678:
  - Frame 0 shows all "0" (3F, inverted 0x40 on {g..a}).
  - From frame 1: slot idx0 has led_en=8'hFE and segments for "8". Slot idx7 has led_en=8'h7F and segments for "1".
- Guard check: in every slot, the first output cycle has led_en=8'hFF and all segments 1. The next 3 cycles have exactly one led_en bit low. A bench monitor asserts the one-hot-low invariant throughout.
- Tearing:
  - Change data from 32'hAAAAAAAA to 32'h55555555 while idx=3.
  - Digits 4..7 of that frame still show "A" (0x77 -> pins 0x08).
  - The next frame shows "5" on all digits.
- Leading-zero blank, blank_lz=1, data=32'h000000F0:
  - Digits 2..7 enabled but segments all 1; digit 1 shows "F"; digit 0 shows "0".
  - data=0 shows only digit 0 = "0".
- dp_mask=8'b0000_0101: led_dp=0 only during non-guard cycles of slots idx0 and idx2, including when those digits are blanked.
- Assert rst mid-slot (cnt=2, idx=5): outputs go dark the same cycle. After release, scan restarts at idx0 with the shadow cleared. Repeat with GUARD=0: no dark cycles except reset.
